// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and helpers for the serial-in/parallel-out deserialiser
package sipo_pkg;

    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_stream_deser_if.sv
// rtl/sipo_stream_deser_if.sv - serial input and parallel output handshake bundle
interface sipo_stream_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic                       sin;
    logic                       sin_valid;
    logic                       sin_ready;
    logic [WIDTH-1:0]           pout;
    logic                       pout_valid;
    logic                       pout_ready;
    logic [cnt_w(WIDTH)-1:0]    bit_cnt;

    modport master (
        output sin, sin_valid, pout_ready,
        input  sin_ready, pout, pout_valid, bit_cnt
    );

    modport slave (
        input  sin, sin_valid, pout_ready,
        output sin_ready, pout, pout_valid, bit_cnt
    );

endinterface

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - shift register and bit counter with a word-complete pulse
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic                    sin,
    output logic [WIDTH-1:0]        word,
    output logic [cnt_w(WIDTH)-1:0] bit_cnt,
    output logic                    done
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        last  = (cnt_q == CW'(WIDTH - 1));
        done  = accept && last;
        if (accept) begin
            if (MSB_FIRST == BIT_ORDER_LSB) begin
                sr_d = {sin, sr_q[WIDTH-1:1]};
            end else begin
                sr_d = {sr_q[WIDTH-2:0], sin};
            end
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // The completed word includes the bit being accepted on this edge.
    assign word    = sr_d;
    assign bit_cnt = cnt_q;

endmodule

// File: rtl/sipo_stream_deser.sv
// rtl/sipo_stream_deser.sv - deserialiser top: shift core plus one-word output holding register
module sipo_stream_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = BIT_ORDER_MSB
) (
    input  logic               clk,
    input  logic               rst,
    sipo_stream_deser_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    logic             accept;
    logic             done;
    logic             sin_ready;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .sin     (bus.sin),
        .word    (word),
        .bit_cnt (bit_cnt),
        .done    (done)
    );

    // Only the completing bit can stall, and only when the held word is not draining.
    assign sin_ready = (bit_cnt != CW'(WIDTH - 1)) || !pout_valid_q || bus.pout_ready;
    assign accept    = bus.sin_valid && sin_ready;

    always_comb begin
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        if (done) begin
            pout_d       = word;
            pout_valid_d = 1'b1;
        end else if (pout_valid_q && bus.pout_ready) begin
            pout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
        end else begin
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
        end
    end

    assign bus.sin_ready  = sin_ready;
    assign bus.pout       = pout_q;
    assign bus.pout_valid = pout_valid_q;
    assign bus.bit_cnt    = bit_cnt;

endmodule

// File: tb/tb_sipo_stream_deser.sv
// tb/tb_sipo_stream_deser.sv - randomized and directed bench for three deserialiser configurations
module tb_sipo_stream_deser;
    import sipo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_stream_deser_if #(.WIDTH(4)) if0 ();
    sipo_stream_deser_if #(.WIDTH(4)) if1 ();
    sipo_stream_deser_if #(.WIDTH(8)) if2 ();

    sipo_stream_deser #(.WIDTH(4), .MSB_FIRST(BIT_ORDER_MSB)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sipo_stream_deser #(.WIDTH(4), .MSB_FIRST(BIT_ORDER_LSB)) u1 (.clk(clk), .rst(rst), .bus(if1));
    sipo_stream_deser #(.WIDTH(8), .MSB_FIRST(BIT_ORDER_MSB)) u2 (.clk(clk), .rst(rst), .bus(if2));

    int vectors = 0;
    int miscompares = 0;

    int       w_of[3]   = '{4, 4, 8};
    bit       msb_of[3] = '{1'b1, 1'b0, 1'b1};

    // Reference model: bits received so far for the current word, plus the held output word.
    int       m_cnt[3];
    bit       m_bits[3][8];
    int       m_pout[3];
    bit       m_pv[3];

    int       o_pout[3];
    int       o_pv[3];
    int       o_ready[3];
    int       o_cnt[3];

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [2:0] v, input logic [2:0] r);
        if0.sin = s[0]; if0.sin_valid = v[0]; if0.pout_ready = r[0];
        if1.sin = s[1]; if1.sin_valid = v[1]; if1.pout_ready = r[1];
        if2.sin = s[2]; if2.sin_valid = v[2]; if2.pout_ready = r[2];
    endtask

    task automatic sample();
        o_pout[0] = int'(if0.pout); o_pv[0] = int'(if0.pout_valid);
        o_ready[0] = int'(if0.sin_ready); o_cnt[0] = int'(if0.bit_cnt);
        o_pout[1] = int'(if1.pout); o_pv[1] = int'(if1.pout_valid);
        o_ready[1] = int'(if1.sin_ready); o_cnt[1] = int'(if1.bit_cnt);
        o_pout[2] = int'(if2.pout); o_pv[2] = int'(if2.pout_valid);
        o_ready[2] = int'(if2.sin_ready); o_cnt[2] = int'(if2.bit_cnt);
    endtask

    function automatic int model_ready(input int k, input logic r);
        return (m_cnt[k] == w_of[k] - 1 && m_pv[k] && !r) ? 0 : 1;
    endfunction

    task automatic check_all(input logic [2:0] r);
        sample();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d.pout", k), o_pout[k], m_pout[k]);
            check($sformatf("u%0d.pout_valid", k), o_pv[k], int'(m_pv[k]));
            check($sformatf("u%0d.bit_cnt", k), o_cnt[k], m_cnt[k]);
            check($sformatf("u%0d.sin_ready", k), o_ready[k], model_ready(k, r[k]));
        end
    endtask

    task automatic model_update(input logic [2:0] s, input logic [2:0] v, input logic [2:0] r);
        for (int k = 0; k < 3; k++) begin
            bit acc;
            acc = v[k] && (model_ready(k, r[k]) != 0);
            if (acc) begin
                m_bits[k][m_cnt[k]] = s[k];
                m_cnt[k]++;
            end
            if (acc && m_cnt[k] == w_of[k]) begin
                int word = 0;
                for (int i = 0; i < w_of[k]; i++) begin
                    if (m_bits[k][i]) begin
                        word += msb_of[k] ? (1 << (w_of[k] - 1 - i)) : (1 << i);
                    end
                end
                m_pout[k] = word;
                m_pv[k]   = 1'b1;
                m_cnt[k]  = 0;
            end else if (m_pv[k] && r[k]) begin
                m_pv[k] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [2:0] s, input logic [2:0] v, input logic [2:0] r);
        drive(s, v, r);
        @(negedge clk);
        check_all(r);
        model_update(s, v, r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'($urandom), 3'($urandom), 3'($urandom));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_pout[k] = 0; m_pv[k] = 1'b0;
        end
        sample();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst.u%0d.pout", k), o_pout[k], 0);
            check($sformatf("rst.u%0d.pout_valid", k), o_pv[k], 0);
            check($sformatf("rst.u%0d.bit_cnt", k), o_cnt[k], 0);
            check($sformatf("rst.u%0d.sin_ready", k), o_ready[k], 1);
        end
    endtask

    initial begin
        logic [3:0]  seq;
        logic [15:0] stream;
        logic [6:0]  vs;
        logic [6:0]  bs;
        int          exp_cnt[4] = '{1, 2, 3, 0};

        drive(3'b000, 3'b000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Bits 1,0,1,1 into both bit orders, output always ready.
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            step({3{seq[3-i]}}, 3'b111, 3'b111);
            sample();
            check("t1.bit_cnt", o_cnt[0], exp_cnt[i]);
        end
        sample();
        check("t1.msb_pout", o_pout[0], 'hB);
        check("t2.lsb_pout", o_pout[1], 'hD);
        check("t1.pout_valid", o_pv[0], 1);
        step(3'b000, 3'b000, 3'b111);
        sample();
        check("t1.valid_one_cycle", o_pv[0], 0);

        // Back-to-back 0xA5, 0x3C on the 8-bit instance.
        do_reset();
        stream = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            step({3{stream[15-i]}}, 3'b111, 3'b111);
            sample();
            if (i == 7) begin
                check("t3.word0", o_pout[2], 'hA5);
                check("t3.word0_valid", o_pv[2], 1);
            end
            if (i == 8) check("t3.word0_consumed", o_pv[2], 0);
            if (i == 15) begin
                check("t3.word1", o_pout[2], 'h3C);
                check("t3.word1_valid", o_pv[2], 1);
            end
        end

        // Backpressure: completing bit stalls until the output drains.
        do_reset();
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) step({3{seq[3-i]}}, 3'b111, 3'b000);
        seq = 4'b0110;
        for (int i = 0; i < 3; i++) step({3{seq[3-i]}}, 3'b111, 3'b000);
        step(3'b000, 3'b111, 3'b000);
        sample();
        check("t4.stall_ready", o_ready[0], 0);
        check("t4.stall_cnt", o_cnt[0], 3);
        check("t4.hold_pout", o_pout[0], 'hB);
        check("t4.hold_valid", o_pv[0], 1);
        step(3'b000, 3'b111, 3'b111);
        sample();
        check("t4.drain_pout", o_pout[0], 'h6);
        check("t4.no_bubble", o_pv[0], 1);

        // Gaps in sin_valid; ignored bits carry random values.
        do_reset();
        vs = 7'b1001101;
        bs = 7'b1000101;
        for (int i = 0; i < 7; i++) begin
            logic b;
            b = vs[6-i] ? bs[6-i] : 1'($urandom);
            step({3{b}}, {3{vs[6-i]}}, 3'b111);
        end
        sample();
        check("t5.gap_pout", o_pout[0], 'hB);

        // Mid-word reset discards partial bits.
        do_reset();
        step(3'b111, 3'b111, 3'b111);
        step(3'b111, 3'b111, 3'b111);
        sample();
        check("t6.partial_cnt", o_cnt[0], 2);
        do_reset();
        seq = 4'b0011;
        for (int i = 0; i < 4; i++) step({3{seq[3-i]}}, 3'b111, 3'b111);
        sample();
        check("t6.after_rst_pout", o_pout[0], 'h3);

        // Randomized traffic with sporadic resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                logic [2:0] v;
                logic [2:0] r;
                for (int k = 0; k < 3; k++) begin
                    v[k] = ($urandom_range(0, 3) != 0);
                    r[k] = ($urandom_range(0, 1) != 0);
                end
                step(3'($urandom), v, r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
